// File: rtl/pe_operand_dispatcher.sv
// Single-PE operand dispatcher: fetches act/weight pairs, hands them to the PE, writes results back.
// Optional result-wait timeout is compiled in with `define PE_DISPATCH_TIMEOUT_EN.
module pe_operand_dispatcher #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 16,
  parameter int RES_W          = 40,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              op_rd_en,
  output logic [ADDR_W-1:0] op_rd_addr,
  input  logic [DATA_W-1:0] act_rd_data,
  input  logic [DATA_W-1:0] wt_rd_data,
  output logic [DATA_W-1:0] pe_input_data,
  output logic              pe_input_valid,
  input  logic              pe_input_ready,
  output logic [DATA_W-1:0] pe_weight_data,
  output logic              pe_weight_valid,
  input  logic              pe_weight_ready,
  input  logic [RES_W-1:0]  pe_result_data,
  input  logic              pe_result_valid,
  output logic              pe_result_ready,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [RES_W-1:0]  res_wr_data
);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, ISSUE, WAIT_RES, WRITE, FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic              in_hs;

  assign in_hs = pe_input_valid & pe_weight_valid & pe_input_ready & pe_weight_ready;

`ifdef PE_DISPATCH_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             error_q;
  assign error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign error          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base_q          <= '0;
      len_q           <= '0;
      idx             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      op_rd_en        <= 1'b0;
      op_rd_addr      <= '0;
      pe_input_data   <= '0;
      pe_weight_data  <= '0;
      pe_input_valid  <= 1'b0;
      pe_weight_valid <= 1'b0;
      pe_result_ready <= 1'b0;
      res_wr_en       <= 1'b0;
      res_wr_addr     <= '0;
      res_wr_data     <= '0;
`ifdef PE_DISPATCH_TIMEOUT_EN
      wait_cnt        <= '0;
      error_q         <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      op_rd_en  <= 1'b0;
      res_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= length;
            idx    <= '0;
            busy   <= 1'b1;
`ifdef PE_DISPATCH_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            if (length == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              op_rd_en   <= 1'b1;
              op_rd_addr <= base_addr;
              state      <= FETCH;
            end
          end
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          // holding registers double as the PE data outputs
          pe_input_data   <= act_rd_data;
          pe_weight_data  <= wt_rd_data;
          pe_input_valid  <= 1'b1;
          pe_weight_valid <= 1'b1;
          state           <= ISSUE;
        end
        ISSUE: begin
          if (in_hs) begin
            pe_input_valid  <= 1'b0;
            pe_weight_valid <= 1'b0;
            pe_result_ready <= 1'b1;
            state           <= WAIT_RES;
`ifdef PE_DISPATCH_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
          end
        end
        WAIT_RES: begin
          if (pe_result_valid) begin
            pe_result_ready <= 1'b0;
            res_wr_data     <= pe_result_data;
            res_wr_addr     <= base_q + idx;
            res_wr_en       <= 1'b1;
            state           <= WRITE;
          end
`ifdef PE_DISPATCH_TIMEOUT_EN
          // a result on the limit cycle takes priority over the timeout
          else if (wait_cnt == CNT_LAST) begin
            pe_result_ready <= 1'b0;
            error_q         <= 1'b1;
            done            <= 1'b1;
            state           <= FINISH;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        WRITE: begin
          if (idx == len_q - ONE) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            idx        <= idx + ONE;
            op_rd_en   <= 1'b1;
            op_rd_addr <= base_q + idx + ONE;
            state      <= FETCH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_dispatcher.sv
// Scoreboard bench for pe_operand_dispatcher: SRAM + PE models, expected reads/writes queued at start.
module tb_pe_operand_dispatcher;
  localparam int AW = 10, DW = 16, RW = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0, length = '0;
  logic          busy, done, error, op_rd_en;
  logic [AW-1:0] op_rd_addr, res_wr_addr;
  logic [DW-1:0] act_rd_data = '0, wt_rd_data = '0, pe_input_data, pe_weight_data;
  logic          pe_input_valid, pe_weight_valid, pe_result_ready, res_wr_en;
  logic          pe_input_ready = 1'b1, pe_weight_ready = 1'b1;
  logic [RW-1:0] pe_result_data, res_wr_data;
  logic          pe_result_valid;

  pe_operand_dispatcher #(.ADDR_W(AW), .DATA_W(DW), .RES_W(RW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .error(error), .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
    .act_rd_data(act_rd_data), .wt_rd_data(wt_rd_data),
    .pe_input_data(pe_input_data), .pe_input_valid(pe_input_valid), .pe_input_ready(pe_input_ready),
    .pe_weight_data(pe_weight_data), .pe_weight_valid(pe_weight_valid), .pe_weight_ready(pe_weight_ready),
    .pe_result_data(pe_result_data), .pe_result_valid(pe_result_valid), .pe_result_ready(pe_result_ready),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // operand SRAMs, 1-cycle read latency
  logic [DW-1:0] act_mem [0:(1<<AW)-1];
  logic [DW-1:0] wt_mem  [0:(1<<AW)-1];
  always @(posedge clk)
    if (op_rd_en) begin
      act_rd_data <= act_mem[op_rd_addr];
      wt_rd_data  <= wt_mem[op_rd_addr];
    end

  // PE model: two compute cycles after the handshake, valid gated by ready
  bit        pe_respond = 1'b1;
  int        pe_cnt = 0;
  logic      pe_has = 1'b0;
  logic [RW-1:0] pe_res = '0;
  assign pe_result_valid = pe_has & pe_result_ready;
  assign pe_result_data  = pe_res;
  always @(posedge clk) begin
    if (rst) begin
      pe_cnt <= 0;
      pe_has <= 1'b0;
    end else begin
      if (pe_input_valid && pe_weight_valid && pe_input_ready && pe_weight_ready && pe_respond) begin
        pe_res <= RW'(pe_input_data) * RW'(pe_weight_data);
        pe_cnt <= 2;
      end else if (pe_cnt != 0) begin
        pe_cnt <= pe_cnt - 1;
        if (pe_cnt == 1) pe_has <= 1'b1;
      end
      if (pe_result_valid) pe_has <= 1'b0;
    end
  end

  // scoreboard queues and monitor
  logic [AW-1:0] rd_q[$], wr_addr_q[$];
  logic [RW-1:0] wr_data_q[$];
  int rd_cyc[$];
  int cyc = 0, n_rd = 0, n_wr = 0, n_done = 0, n_hs = 0, rdy_cyc = 0;
  int start_cyc = 0, done_cyc = 0, last_wr_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (start && !busy) start_cyc = cyc;
      if (op_rd_en) begin
        n_rd++;
        rd_cyc.push_back(cyc);
        if (rd_q.size() == 0) chk("rd_extra", rd_q.size(), 1);
        else chk("rd_addr", op_rd_addr, rd_q.pop_front());
      end
      if (res_wr_en) begin
        n_wr++;
        last_wr_cyc = cyc;
        if (wr_addr_q.size() == 0) chk("wr_extra", wr_addr_q.size(), 1);
        else begin
          chk("wr_addr", res_wr_addr, wr_addr_q.pop_front());
          chk("wr_data", res_wr_data, wr_data_q.pop_front());
        end
      end
      if (pe_input_valid && pe_weight_valid && pe_input_ready && pe_weight_ready) begin
        n_hs++;
        chk("rr_in_hs", pe_result_ready, 0);
      end
      if (pe_result_ready) rdy_cyc++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input int n_rd_exp, input bit wr_exp);
    for (int i = 0; i < n_rd_exp; i++) begin
      logic [AW-1:0] a;
      a = AW'(b + AW'(i));
      rd_q.push_back(a);
      if (wr_exp) begin
        wr_addr_q.push_back(a);
        wr_data_q.push_back(RW'(act_mem[a]) * RW'(wt_mem[a]));
      end
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {busy, done, error, op_rd_en, res_wr_en, pe_input_valid, pe_weight_valid, pe_result_ready}, 0);
    chk({tag, "_addr"}, {op_rd_addr, res_wr_addr}, 0);
    chk({tag, "_wdata"}, res_wr_data, 0);
    chk({tag, "_pedata"}, {pe_input_data, pe_weight_data}, 0);
  endtask

  initial begin
    int d0, r0, w0, h0;
    bit ok;
    for (int i = 0; i < (1 << AW); i++) begin
      act_mem[i] = DW'(i * 37 + 11);
      wt_mem[i]  = DW'(16'hF00F ^ DW'(i * 13));
    end
    repeat (3) @(posedge clk);
    #1 chk_quiet("reset");
    rst = 1'b0;

    // basic run, 7 cycles per element
    d0 = n_done; rd_cyc.delete();
    do_start(10'h010, 10'd3, 3, 1'b1);
    wait_done("t1");
    chk("t1_error", error, 0);
    chk("t1_nrd", rd_cyc.size(), 3);
    if (rd_cyc.size() == 3) begin
      chk("t1_start2rd", rd_cyc[0] - start_cyc, 1);
      chk("t1_gap0", rd_cyc[1] - rd_cyc[0], 7);
      chk("t1_gap1", rd_cyc[2] - rd_cyc[1], 7);
    end
    chk("t1_wr2done", done_cyc - last_wr_cyc, 1);
    tick();
    chk("t1_done_cnt", n_done - d0, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_q_empty", rd_q.size() + wr_addr_q.size(), 0);

    // zero length
    r0 = n_rd; w0 = n_wr;
    do_start(10'h123, 10'd0, 0, 1'b0);
    chk("t2_done_busy", {done, busy}, 2'b11);
    @(posedge clk); #1;
    chk("t2_after", {done, busy}, 2'b00);
    chk("t2_latency", done_cyc - start_cyc, 1);
    repeat (3) tick();
    chk("t2_no_rw", (n_rd - r0) + (n_wr - w0), 0);

    // weight-ready stall: valids and data held 5 cycles, one handshake
    h0 = n_hs; w0 = n_wr;
    pe_weight_ready = 1'b0;
    do_start(10'h100, 10'd1, 1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (pe_input_valid) ok = 1'b1;
    end
    chk("t3_valid_seen", ok, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_valids", {pe_input_valid, pe_weight_valid}, 2'b11);
      chk("t3_data", {pe_input_data, pe_weight_data}, {act_mem[10'h100], wt_mem[10'h100]});
      if (k < 4) begin
        @(posedge clk); #1;
        if (k == 3) pe_weight_ready = 1'b1;
        tick();
      end
    end
    wait_done("t3");
    chk("t3_hs", n_hs - h0, 1);
    chk("t3_wr", n_wr - w0, 1);

    // address wrap
    do_start(10'h3FE, 10'd4, 4, 1'b1);
    wait_done("t4");
    tick();
    chk("t4_q_empty", rd_q.size() + wr_addr_q.size(), 0);

    // restart ignored while busy, then reset in element 1 WAIT_RES
    d0 = n_done;
    do_start(10'h020, 10'd3, 3, 1'b1);
    w0 = n_wr;
    repeat (2) tick();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h200; length = 10'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_busy", busy, 1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (pe_result_ready && n_wr == w0 + 1) ok = 1'b1;
    end
    chk("t5_reached_wait", ok, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    @(posedge clk); #1;
    chk_quiet("t5_rst");
    rst = 1'b0;
    r0 = n_rd; w0 = n_wr;
    repeat (20) tick();
    chk("t5_no_done", n_done - d0, 0);
    chk("t5_no_rw", (n_rd - r0) + (n_wr - w0), 0);
    d0 = n_done;
    do_start(10'h030, 10'd2, 2, 1'b1);
    wait_done("t5b");
    tick();
    chk("t5b_done_cnt", n_done - d0, 1);
    chk("t5b_q_empty", rd_q.size() + wr_addr_q.size(), 0);

`ifdef PE_DISPATCH_TIMEOUT_EN
    // PE never answers: timeout after 8 WAIT_RES cycles
    pe_respond = 1'b0;
    w0 = n_wr; rdy_cyc = 0;
    do_start(10'h040, 10'd3, 1, 1'b0);
    wait_done("t6");
    chk("t6_error", error, 1);
    chk("t6_wait_cycles", rdy_cyc, 8);
    chk("t6_no_wr", n_wr - w0, 0);
    tick();
    chk("t6_sticky", {error, busy}, 2'b10);
    pe_respond = 1'b1;
    do_start(10'h050, 10'd1, 1, 1'b1);
    chk("t6_err_clr", error, 0);
    wait_done("t6b");
    tick();
    chk("t6b_q_empty", rd_q.size() + wr_addr_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_operand_dispatcher.md
# pe_operand_dispatcher

Initiator-side controller that feeds a single `processing_element` and drains its results. For a programmed run of N elements it reads paired activation/weight words from the operand buffers, presents them on the PE's input and weight valid/ready ports, waits for the PE's result, and writes each result to the result buffer at the matching index. It sits between the local operand/result SRAMs and one PE. It keeps at most one transaction outstanding because the PE is not pipelined.

## Interface
Parameters:
- `ADDR_W`, 10, operand/result buffer address width
- `DATA_W`, 16, activation and weight word width
- `RES_W`, 40, PE result width
- `TIMEOUT_CYCLES`, 256, result-wait limit; used only when `PE_DISPATCH_TIMEOUT_EN` is defined

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; begins a run when idle
- `base_addr`  in  ADDR_W  first buffer index of the run
- `length`  in  ADDR_W  number of elements in the run (0 allowed)
- `busy`  out  1  high from the accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse when the run ends
- `error`  out  1  sticky timeout flag; cleared by the next accepted `start`
- `op_rd_en`  out  1  read strobe to both operand buffers
- `op_rd_addr`  out  ADDR_W  shared read address
- `act_rd_data`  in  DATA_W  activation word, valid 1 cycle after `op_rd_en`
- `wt_rd_data`  in  DATA_W  weight word, valid 1 cycle after `op_rd_en`
- `pe_input_data`  out  DATA_W  to PE input
- `pe_input_valid`  out  1
- `pe_input_ready`  in  1
- `pe_weight_data`  out  DATA_W  to PE weight
- `pe_weight_valid`  out  1
- `pe_weight_ready`  in  1
- `pe_result_data`  in  RES_W  from PE output
- `pe_result_valid`  in  1
- `pe_result_ready`  out  1
- `res_wr_en`  out  1  result buffer write strobe
- `res_wr_addr`  out  ADDR_W
- `res_wr_data`  out  RES_W

## Operation
- States: IDLE, FETCH, CAPTURE, ISSUE, WAIT_RES, WRITE, FINISH.
- **IDLE:** When `start` is high, latch `base_addr` and `length`, clear `idx` and `error`, and assert `busy`.
  - If `length==0`, go to FINISH.
  - Otherwise go to FETCH.
- **FETCH:** Drive `op_rd_en=1` and `op_rd_addr=base+idx` for exactly one cycle, then go to CAPTURE.
- **CAPTURE:** Register `act_rd_data` and `wt_rd_data` into holding registers, then go to ISSUE.
- **ISSUE:**
  - Assert `pe_input_valid` and `pe_weight_valid` together from the holding registers.
  - Data stays stable until handshake.
  - The handshake completes in the cycle where both valids are high and both `pe_input_ready` and `pe_weight_ready` are high. On that cycle, go to WAIT_RES.
  - Valids must never be dropped before the handshake completes.
- **WAIT_RES:**
  - `pe_result_ready` is held high for the whole state, because the PE gates its valid with ready.
  - On `pe_result_valid`, capture `pe_result_data` and go to WRITE.
- **WRITE:**
  - Drive `res_wr_en=1` for one cycle, with `res_wr_addr=base+idx` and `res_wr_data` set to the captured result.
  - If `idx==length-1`, go to FINISH. Otherwise increment `idx` and go to FETCH.
- **FINISH:** Pulse `done` for one cycle and return to IDLE. `busy` drops in the cycle after `done`.
- Address arithmetic is modulo 2^ADDR_W; `base+idx` wraps silently.
- `start` while `busy` is ignored; the latched parameters stay unchanged.
- `pe_result_valid` outside WAIT_RES is ignored, and `pe_result_ready` is 0 outside WAIT_RES.

## Timing
- Reset values: state=IDLE; `idx`, holding regs and result reg are 0; every output is 0, including `busy`, `done`, `error`, `op_rd_addr`, `res_wr_addr` and `res_wr_data`.
- `rst` has priority over every other input in the same cycle.
  - A reset mid-run returns to IDLE immediately.
  - No `done` is produced and no further reads or writes are issued.
- Per-element minimum is 5 cycles (FETCH, CAPTURE, ISSUE, WAIT_RES, WRITE). Stalls in ISSUE and WAIT_RES add cycles one-for-one.
- `start` to first `op_rd_en` is 1 cycle.
- `done` comes 1 cycle after the last `res_wr_en`.
- With `length==0`, `done` comes 1 cycle after `start`.
- The handshake-completion cycle and the WAIT_RES entry are consecutive; the dispatcher never asserts `pe_result_ready` in the same cycle as the input handshake.

## Configuration
- `PE_DISPATCH_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT_RES and increments each cycle there.
  - When it reaches `TIMEOUT_CYCLES` without `pe_result_valid`, the dispatcher sets `error=1`, skips WRITE and the remaining elements, and goes to FINISH, which pulses `done`.
  - If `pe_result_valid` arrives on the same cycle the limit is reached, the result wins and no timeout is flagged.
- Not defined: no counter is built, WAIT_RES waits indefinitely, and `error` is tied to 0.

## Test plan
- `base=0x010`, `length=3`, PE model with ready always high and result 2 cycles after handshake → reads at 0x010/0x011/0x012, writes at the same addresses with matching results, `done` once, 7 cycles per element.
- `length=0` `start` → no `op_rd_en`, no `res_wr_en`, `done` and `busy` for 1 cycle.
- PE holds `pe_weight_ready=0` for 4 cycles while `pe_input_ready=1` → valids and data stable for 5 cycles, a single handshake, and one result write.
- `base=0x3FE`, `length=4` → addresses 0x3FE, 0x3FF, 0x000, 0x001 for both reads and writes.
- `start` re-pulsed during a run, and `rst` asserted in WAIT_RES of element 1 → the second start is ignored; after reset all outputs are 0, there is no `done`, and a subsequent run behaves normally.
- With `PE_DISPATCH_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, PE never returns a result → `done` and `error=1` after 8 WAIT_RES cycles, with no `res_wr_en`.
